// File: rtl/autosym_pla_eval.sv
// autosym_pla_eval: sequential multi-output PLA cover evaluator
// with optional GF(2) XOR input projection, one cube per cycle.
module autosym_pla_eval #(
  parameter  int N_IN  = 15,
  parameter  int N_OUT = 1,
  parameter  int DEPTH = 64,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int MAW   = $clog2(DEPTH),
  localparam int RAW   = $clog2(N_IN),
  localparam int CAW   = (MAW > RAW) ? MAW : RAW,
  localparam int DW    = 2 * N_IN + N_OUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [CAW-1:0]   cfg_addr,
  input  logic [DW-1:0]    cfg_data,
  output logic             cfg_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] out_y
);

  typedef enum logic [1:0] {
    S_IDLE, S_PROJ, S_SCAN, S_HOLD
  } state_t;

  state_t            r_state;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_cfg_err;
  logic [N_OUT-1:0]  r_out_y;
  logic [N_OUT-1:0]  r_acc;
  logic [N_IN-1:0]   r_x;
  logic [N_IN-1:0]   r_z;
  logic [CW-1:0]     r_idx;
  logic [CW-1:0]     r_ncubes;
  logic              r_proj_en;
  logic              r_out_pol;
  logic [N_IN-1:0]   r_p   [N_IN];
  logic [DW-1:0]     r_mem [DEPTH];

  logic              w_in_hs;
  logic              w_sel_bad;
  logic              w_wr;
  logic [CW-1:0]     w_nc;
  logic [N_IN-1:0]   w_z_nx;
  logic [DW-1:0]     w_cube;
  logic              w_match;
  logic [N_OUT-1:0]  w_acc_nx;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_y     = r_out_y;
  assign cfg_err   = r_cfg_err;

  assign w_in_hs = in_valid & r_in_ready;

  // classify the config target as valid or dropped
  always_comb begin
    w_sel_bad = 1'b1;
    unique case (cfg_sel)
      2'b00:   w_sel_bad = (32'(cfg_addr) >= DEPTH);
      2'b01:   w_sel_bad = (32'(cfg_addr) >= N_IN);
      2'b10:   w_sel_bad = 1'b0;
      default: w_sel_bad = 1'b1;
    endcase
  end

  assign w_wr = cfg_we & (r_state == S_IDLE)
              & ~w_in_hs & ~w_sel_bad;

  assign w_nc = (32'(cfg_data[CW-1:0]) > DEPTH)
              ? CW'(DEPTH) : cfg_data[CW-1:0];

  // projected vector: row parity of x under P, or x itself
  always_comb begin
    w_z_nx = '0;
    for (int k = 0; k < N_IN; k++)
      w_z_nx[k] = r_proj_en ? ^(r_x & r_p[k]) : r_x[k];
  end

  assign w_cube   = r_mem[r_idx[MAW-1:0]];
  assign w_match  = ((r_z ^ w_cube[2*N_IN-1:N_IN])
                    & w_cube[N_IN-1:0]) == '0;
  assign w_acc_nx = r_acc
                  | (w_match ? w_cube[DW-1:2*N_IN] : '0);

  // cube store, deliberately left unreset
  always_ff @(posedge clk) begin
    if (w_wr && cfg_sel == 2'b00)
      r_mem[cfg_addr[MAW-1:0]] <= cfg_data;
  end

  // control registers, projection rows and error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ncubes  <= '0;
      r_proj_en <= 1'b0;
      r_out_pol <= 1'b0;
      r_cfg_err <= 1'b0;
      for (int k = 0; k < N_IN; k++)
        r_p[k] <= N_IN'(1) << k;
    end else begin
      r_cfg_err <= cfg_we & ~w_wr;
      if (w_wr && cfg_sel == 2'b10) begin
        r_ncubes  <= w_nc;
        r_proj_en <= cfg_data[CW];
        r_out_pol <= cfg_data[CW+1];
      end
      for (int k = 0; k < N_IN; k++)
        if (w_wr && cfg_sel == 2'b01
            && cfg_addr == CAW'(k))
          r_p[k] <= cfg_data[N_IN-1:0];
    end
  end

  // evaluation FSM with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_y     <= '0;
      r_acc       <= '0;
      r_x         <= '0;
      r_z         <= '0;
      r_idx       <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_x        <= in_x;
            r_acc      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_PROJ;
          end
        end
        S_PROJ: begin
          r_z   <= w_z_nx;
          r_idx <= '0;
          if (r_ncubes == '0) begin
            r_acc   <= '0;
            r_state <= S_HOLD;
          end else begin
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          r_acc <= w_acc_nx;
          r_idx <= r_idx + CW'(1);
          if (r_idx == r_ncubes - CW'(1) || &w_acc_nx)
            r_state <= S_HOLD;
        end
        S_HOLD: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_out_valid <= 1'b1;
            r_out_y     <= r_acc ^ {N_OUT{r_out_pol}};
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_autosym_pla_eval.sv
// tb_autosym_pla_eval: directed vectors against autosym_pla_eval
// with hand-computed results and latencies.
module tb_autosym_pla_eval;

  localparam int N_IN  = 15;
  localparam int N_OUT = 1;
  localparam int DW    = 31;
  localparam int CAW   = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_we = 1'b0;
  logic [1:0]       cfg_sel = '0;
  logic [CAW-1:0]   cfg_addr = '0;
  logic [DW-1:0]    cfg_data = '0;
  logic             cfg_err;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N_IN-1:0]  in_x = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [N_OUT-1:0] out_y;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  autosym_pla_eval dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_err   (cfg_err),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y)
  );

  function automatic logic [DW-1:0] cube(
    input logic om, input logic [14:0] val,
    input logic [14:0] care);
    return {om, val, care};
  endfunction

  function automatic logic [DW-1:0] ctrl(
    input logic pol, input logic pe, input int n);
    logic [DW-1:0] d;
    d = '0;
    d[6:0] = 7'(n);
    d[7] = pe;
    d[8] = pol;
    return d;
  endfunction

  task automatic cfg_wr(input logic [1:0] sel,
                        input int addr,
                        input logic [DW-1:0] d);
    cfg_we = 1'b1;
    cfg_sel = sel;
    cfg_addr = CAW'(addr);
    cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic run_vec(input string nm,
                         input logic [N_IN-1:0] x,
                         input logic exp_y,
                         input int exp_lat);
    int w;
    int lat;
    w = 0;
    while (!in_ready && w < 200) begin
      @(posedge clk); #1; w++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready: got %b expected 1", nm, in_ready);
    end
    in_valid = 1'b1;
    in_x = x;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", nm, lat, exp_lat);
    end
    checks++;
    if (out_y !== exp_y) begin
      errors++;
      $display("FAIL %s out_y: got %b expected %b", nm, out_y, exp_y);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s drain: got v=%b r=%b expected v=0 r=1",
               nm, out_valid, in_ready);
    end
  endtask

  task automatic check_idle_outs(input string nm);
    checks++;
    if ({in_ready, out_valid, out_y, cfg_err} !== 4'b1000) begin
      errors++;
      $display("FAIL %s: got r=%b v=%b y=%b e=%b expected r=1 v=0 y=0 e=0",
               nm, in_ready, out_valid, out_y, cfg_err);
    end
  endtask

  task automatic setup_basic();
    cfg_wr(2'b00, 0, cube(1'b1, 15'h0001, 15'h0003));
    cfg_wr(2'b01, 0, 31'h0000_0001);
    cfg_wr(2'b10, 0, ctrl(1'b0, 1'b0, 1));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outs("reset_state");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle_outs("after_release");
  endtask

  task automatic test_basic();
    setup_basic();
    run_vec("basic_0001", 15'h0001, 1'b1, 3);
    run_vec("basic_0003", 15'h0003, 1'b0, 3);
    run_vec("basic_7ff1", 15'h7FF1, 1'b1, 3);
  endtask

  task automatic test_proj();
    cfg_wr(2'b00, 0, cube(1'b1, 15'h0001, 15'h0001));
    cfg_wr(2'b01, 0, 31'h0000_0003);
    cfg_wr(2'b10, 0, ctrl(1'b0, 1'b1, 1));
    run_vec("proj_0001", 15'h0001, 1'b1, 3);
    run_vec("proj_0003", 15'h0003, 1'b0, 3);
    run_vec("proj_0002", 15'h0002, 1'b1, 3);
    cfg_wr(2'b10, 0, ctrl(1'b1, 1'b1, 1));
    run_vec("pol_0001", 15'h0001, 1'b0, 3);
    run_vec("pol_0003", 15'h0003, 1'b1, 3);
    run_vec("pol_0002", 15'h0002, 1'b0, 3);
  endtask

  task automatic test_early();
    for (int i = 1; i < 63; i++)
      cfg_wr(2'b00, i, cube(1'b1, 15'h6DCB, 15'h7FFF));
    cfg_wr(2'b00, 63, cube(1'b1, 15'h1234, 15'h7FFF));
    cfg_wr(2'b00, 0, cube(1'b1, 15'h0000, 15'h0000));
    cfg_wr(2'b01, 0, 31'h0000_0001);
    cfg_wr(2'b10, 0, ctrl(1'b0, 1'b0, 64));
    run_vec("early_cube0", 15'h1234, 1'b1, 3);
    cfg_wr(2'b00, 0, cube(1'b1, 15'h6DCB, 15'h7FFF));
    run_vec("full_cube63", 15'h1234, 1'b1, 66);
    run_vec("full_nomatch", 15'h0000, 1'b0, 66);
    cfg_wr(2'b10, 0, ctrl(1'b0, 1'b0, 127));
    run_vec("sat_127", 15'h1234, 1'b1, 66);
    cfg_wr(2'b10, 0, ctrl(1'b0, 1'b0, 0));
    run_vec("zero_cubes", 15'h1234, 1'b0, 2);
  endtask

  task automatic test_reset_mid_scan();
    int stray;
    cfg_wr(2'b10, 0, ctrl(1'b0, 1'b0, 64));
    in_valid = 1'b1;
    in_x = 15'h0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_idle_outs("reset_mid_scan");
    rst_n = 1'b1;
    stray = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (out_valid) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL no_stray_valid: got %0d cycles expected 0", stray);
    end
  endtask

  task automatic test_hold();
    int lat;
    setup_basic();
    in_valid = 1'b1;
    in_x = 15'h0001;
    @(posedge clk); #1;
    in_x = 15'h0003;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL hold_latency: got %0d expected 3", lat);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_y !== 1'b1
          || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable[%0d]: got v=%b y=%b r=%b expected v=1 y=1 r=0",
                 i, out_valid, out_y, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_drain: got v=%b r=%b expected v=0 r=1",
               out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL hold_accept_next: got r=%b expected 0", in_ready);
    end
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat !== 3 || out_y !== 1'b0) begin
      errors++;
      $display("FAIL hold_second: got lat=%0d y=%b expected lat=3 y=0",
               lat, out_y);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_cfg_err();
    int lat;
    in_valid = 1'b1;
    in_x = 15'h0001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    cfg_we = 1'b1;
    cfg_sel = 2'b10;
    cfg_addr = '0;
    cfg_data = ctrl(1'b1, 1'b0, 0);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL err_scan: got %b expected 1", cfg_err);
    end
    @(posedge clk); #1;
    checks++;
    if (cfg_err !== 1'b0 || out_valid !== 1'b1 || out_y !== 1'b1) begin
      errors++;
      $display("FAIL err_scan_after: got e=%b v=%b y=%b expected e=0 v=1 y=1",
               cfg_err, out_valid, out_y);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    cfg_wr(2'b11, 0, ctrl(1'b1, 1'b1, 0));
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sel11: got %b expected 1", cfg_err);
    end
    cfg_wr(2'b01, 15, 31'h0000_7FFF);
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL err_row15: got %b expected 1", cfg_err);
    end
    @(posedge clk); #1;
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse_len: got %b expected 0", cfg_err);
    end
    cfg_wr(2'b01, 14, 31'h0000_4000);
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL err_row14_ok: got %b expected 0", cfg_err);
    end

    in_valid = 1'b1;
    in_x = 15'h0001;
    cfg_we = 1'b1;
    cfg_sel = 2'b10;
    cfg_addr = '0;
    cfg_data = ctrl(1'b1, 1'b0, 0);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL err_same_edge: got %b expected 1", cfg_err);
    end
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat !== 3 || out_y !== 1'b1) begin
      errors++;
      $display("FAIL same_edge_result: got lat=%0d y=%b expected lat=3 y=1",
               lat, out_y);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    run_vec("rerun_0001", 15'h0001, 1'b1, 3);
    run_vec("rerun_0003", 15'h0003, 1'b0, 3);
    run_vec("rerun_7ff1", 15'h7FF1, 1'b1, 3);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_proj();
    test_early();
    test_reset_mid_scan();
    test_hold();
    test_cfg_err();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
